// File: rtl/psram_arb_pkg.sv
// Shared constants for the scratch-memory arbiter: state encoding and default sizes.
package psram_arb_pkg;

  localparam int unsigned AW_DEF  = 23;
  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned TMO_DEF = 4;

  // Timeout counter width; covers TMO up to 15.
  localparam int unsigned CW = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/psram_rr_pick.sv
// Combinational 2-way round-robin pick; on contention the port that did not win last time is chosen.
module psram_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt
);

  // Pick the single requester, or the one other than last when both request.
  always_comb begin
    gnt_valid = |req;
    gnt       = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port round-robin arbiter and single-strobe access sequencer for the scratch memory wrapper.
module psram_arbiter
  import psram_arb_pkg::*;
#(
  parameter int unsigned AW  = AW_DEF,
  parameter int unsigned DW  = DW_DEF,
  parameter int unsigned TMO = TMO_DEF
) (
  input  logic          clkin,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_done,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_done,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] memaddr,
  output logic [DW-1:0] memdatao,
  output logic          memrd,
  output logic          memwr,
  input  logic [DW-1:0] memdatai,
  input  logic          memack
);

  logic [1:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          last, last_d;
  logic          gnt, gnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] dato_d;
  logic          rd_d, wr_d;
  logic [1:0]    done_d, err_d;
  logic [DW-1:0] rdata0_d, rdata1_d;

  logic          pick_valid, pick_gnt;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  psram_rr_pick u_pick (
    .req       ({m1_req, m0_req}),
    .last      (last),
    .gnt_valid (pick_valid),
    .gnt       (pick_gnt)
  );

  // Command mux from the port the picker chose.
  always_comb begin
    sel_we    = pick_gnt ? m1_we    : m0_we;
    sel_addr  = pick_gnt ? m1_addr  : m0_addr;
    sel_wdata = pick_gnt ? m1_wdata : m0_wdata;
  end

  // Next-state and next-output logic; strobes and done/err are single-cycle by default.
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    last_d   = last;
    gnt_d    = gnt;
    we_d     = we_q;
    addr_d   = memaddr;
    dato_d   = memdatao;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    done_d   = 2'b00;
    err_d    = 2'b00;
    rdata0_d = m0_rdata;
    rdata1_d = m1_rdata;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_gnt;
          last_d  = pick_gnt;
          we_d    = sel_we;
          addr_d  = sel_addr;
          dato_d  = sel_wdata;
          rd_d    = ~sel_we;
          wr_d    = sel_we;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (memack) begin
          done_d[gnt] = 1'b1;
          if (!we_q) begin
            if (gnt) rdata1_d = memdatai;
            else     rdata0_d = memdatai;
          end
          state_d = ST_DONE;
        end else if (cnt == CW'(TMO - 1)) begin
          done_d[gnt] = 1'b1;
          err_d[gnt]  = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer control registers; last resets to 1 so port 0 wins the first contest.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      gnt   <= 1'b0;
      we_q  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      last  <= last_d;
      gnt   <= gnt_d;
      we_q  <= we_d;
    end
  end

  // Memory-side outputs: address/data hold from grant through WAIT.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      memaddr  <= '0;
      memdatao <= '0;
      memrd    <= 1'b0;
      memwr    <= 1'b0;
    end else begin
      memaddr  <= addr_d;
      memdatao <= dato_d;
      memrd    <= rd_d;
      memwr    <= wr_d;
    end
  end

  // Requester-side outputs: completion pulses and captured read bytes.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_err   <= 1'b0;
      m1_err   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_done  <= done_d[0];
      m1_done  <= done_d[1];
      m0_err   <= err_d[0];
      m1_err   <= err_d[1];
      m0_rdata <= rdata0_d;
      m1_rdata <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: per-port request drivers, behavioural memory wrapper, completion monitor.
module tb_psram_arbiter;

  localparam int unsigned AW  = 23;
  localparam int unsigned DW  = 8;
  localparam int unsigned TMO = 4;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int            port;
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
  } exp_t;

  logic          clkin = 1'b0;
  logic          rstn  = 1'b0;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic          m0_we = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_done, m1_done, m0_err, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] memaddr;
  logic [DW-1:0] memdatao, memdatai;
  logic          memrd, memwr, memack;

  logic          ack_r = 1'b0;
  logic [DW-1:0] dat_r = '0;
  logic          spur  = 1'b0;
  logic [DW-1:0] mem [0:32767];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   strobe_cyc = 0;
  int   nwr = 0;
  int   present0 = 0, present1 = 0;
  bit   busy0 = 0, busy1 = 0;
  cmd_t cq0[$], cq1[$];
  exp_t expq[$];
  int   done_log[$];

  psram_arbiter #(.AW(AW), .DW(DW), .TMO(TMO)) dut (
    .clkin    (clkin),
    .rstn     (rstn),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_done  (m0_done),
    .m0_err   (m0_err),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_done  (m1_done),
    .m1_err   (m1_err),
    .m1_rdata (m1_rdata),
    .memaddr  (memaddr),
    .memdatao (memdatao),
    .memrd    (memrd),
    .memwr    (memwr),
    .memdatai (memdatai),
    .memack   (memack)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  // Behavioural wrapper: registered ack one cycle after the strobe, only inside the mapped window.
  always @(posedge clkin) begin
    ack_r <= (memrd | memwr) && (memaddr[22:15] == 8'd0);
    if (memrd) dat_r <= mem[memaddr[14:0]];
    if (memwr && memaddr[22:15] == 8'd0) mem[memaddr[14:0]] <= memdatao;
  end
  assign memack   = ack_r | spur;
  assign memdatai = dat_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic err, input logic [DW-1:0] rd, input int lat);
    cmd_t c;
    exp_t e;
    c.we = we; c.addr = a; c.wdata = wd;
    e.port = p; e.err = err; e.rdata = rd; e.lat = lat;
    if (p == 0) cq0.push_back(c); else cq1.push_back(c);
    expq.push_back(e);
  endtask

  // Requesters: hold req until done, then present the next queued command or drop req.
  always @(negedge clkin) begin
    cmd_t c;
    if (!rstn) begin
      m0_req = 1'b0; m1_req = 1'b0;
      busy0 = 0; busy1 = 0;
      cq0.delete(); cq1.delete();
    end else begin
      if (busy0 && m0_done) begin busy0 = 0; m0_req = 1'b0; end
      if (busy1 && m1_done) begin busy1 = 0; m1_req = 1'b0; end
      if (!busy0 && cq0.size() > 0) begin
        c = cq0.pop_front();
        m0_we = c.we; m0_addr = c.addr; m0_wdata = c.wdata;
        m0_req = 1'b1; busy0 = 1; present0 = cyc;
      end
      if (!busy1 && cq1.size() > 0) begin
        c = cq1.pop_front();
        m1_we = c.we; m1_addr = c.addr; m1_wdata = c.wdata;
        m1_req = 1'b1; busy1 = 1; present1 = cyc;
      end
    end
  end

  // Monitor: track strobes and check every completion against the scoreboard.
  logic          md, me;
  logic [DW-1:0] mr;
  exp_t          ex;
  always @(negedge clkin) begin
    if (rstn) begin
      if (memrd || memwr) begin
        strobe_cyc = cyc;
        if (memwr) nwr++;
        chk("strobe_exclusive", 32'(memrd & memwr), 32'd0);
      end
      for (int p = 0; p < 2; p++) begin
        md = (p == 1) ? m1_done  : m0_done;
        me = (p == 1) ? m1_err   : m0_err;
        mr = (p == 1) ? m1_rdata : m0_rdata;
        if (me) chk("err_with_done", 32'(md), 32'd1);
        if (md) begin
          done_log.push_back(cyc);
          chk("done_expected", 32'(expq.size() != 0), 32'd1);
          if (expq.size() != 0) begin
            ex = expq.pop_front();
            chk("grant_port", 32'(p), 32'(ex.port));
            chk("err", 32'(me), 32'(ex.err));
            chk("rdata", 32'(mr), 32'(ex.rdata));
            chk("latency", 32'(cyc - strobe_cyc), 32'(ex.lat));
          end
        end
      end
    end
  end

  task automatic wait_quiet(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clkin);
      if (expq.size() == 0 && !busy0 && !busy1 && cq0.size() == 0 && cq1.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk({name, "_complete"}, 32'(ok), 32'd1);
    repeat (3) @(negedge clkin);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk(name, 32'(|{m0_done, m1_done, m0_err, m1_err, m0_rdata, m1_rdata,
                    memaddr, memdatao, memrd, memwr}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clkin);
    rstn = 1'b0;
    repeat (3) @(negedge clkin);
    chk_outputs_zero("reset_outputs");
    rstn = 1'b1;
    @(negedge clkin);
  endtask

  initial begin
    int nwr0;
    bit seen;
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    mem[4] = 8'h5A;
    mem[6] = 8'h11;
    mem[7] = 8'h22;
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'h80 + 8'(i);

    // Power-on reset.
    repeat (3) @(negedge clkin);
    chk_outputs_zero("por_outputs");
    rstn = 1'b1;
    @(negedge clkin);

    // Single read, port 0: strobe at N+1, done at N+3.
    issue(0, 1'b0, 23'h000004, 8'h00, 1'b0, 8'h5A, 2);
    wait_quiet("t1");
    chk("t1_strobe_offset", 32'(strobe_cyc - present0), 32'd1);

    // Port 1 write, then port 0 reads back and checks the neighbouring byte.
    nwr0 = nwr;
    issue(1, 1'b1, 23'h000007, 8'hC3, 1'b0, 8'h00, 2);
    wait_quiet("t2w");
    chk("t2_write_strobes", 32'(nwr - nwr0), 32'd1);
    issue(0, 1'b0, 23'h000007, 8'h00, 1'b0, 8'hC3, 2);
    issue(0, 1'b0, 23'h000006, 8'h00, 1'b0, 8'h11, 2);
    wait_quiet("t2r");

    // Both ports continuously requesting from reset: alternate 0,1,... every 4 cycles.
    do_reset();
    done_log.delete();
    for (int i = 0; i < 4; i++) begin
      issue(0, 1'b0, 23'(16 + 2 * i), 8'h00, 1'b0, 8'h80 + 8'(2 * i), 2);
      issue(1, 1'b0, 23'(17 + 2 * i), 8'h00, 1'b0, 8'h81 + 8'(2 * i), 2);
    end
    wait_quiet("t3");
    chk("t3_done_count", 32'(done_log.size()), 32'd8);
    for (int i = 1; i < done_log.size(); i++)
      chk("t3_done_spacing", 32'(done_log[i] - done_log[i - 1]), 32'd4);

    // Unmapped read times out with err and rdata unchanged; port 1 then served normally.
    issue(0, 1'b0, 23'h008000, 8'h00, 1'b1, 8'h86, TMO + 1);
    issue(1, 1'b0, 23'h000004, 8'h00, 1'b0, 8'h5A, 2);
    wait_quiet("t4");

    // Spurious ack in IDLE must not produce a completion.
    @(negedge clkin);
    spur = 1'b1;
    @(negedge clkin);
    spur = 1'b0;
    repeat (3) @(negedge clkin);
    issue(0, 1'b0, 23'h000006, 8'h00, 1'b0, 8'h11, 2);
    wait_quiet("t5");
    chk("t5_strobe_offset", 32'(strobe_cyc - present0), 32'd1);

    // Reset mid-write: outputs cleared, no done, port 0 wins after release.
    cq1.push_back('{we: 1'b1, addr: 23'h000005, wdata: 8'hEE});
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkin);
      if (memwr) begin seen = 1; break; end
    end
    chk("t6_write_strobe_seen", 32'(seen), 32'd1);
    @(negedge clkin);
    rstn = 1'b0;
    #1;
    chk_outputs_zero("t6_reset_outputs");
    repeat (3) @(negedge clkin);
    chk_outputs_zero("t6_reset_hold");
    rstn = 1'b1;
    @(negedge clkin);
    issue(0, 1'b0, 23'h000007, 8'h00, 1'b0, 8'hC3, 2);
    issue(1, 1'b0, 23'h000004, 8'h00, 1'b0, 8'h5A, 2);
    wait_quiet("t6");

    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
